// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: ALU operations, forwarding selects
// and write-back source selects.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the Execute stage. Unused operation codes produce 0 so the
// result is always defined.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    // NOTE: assign a default first so every path writes result; a missing branch would infer a latch.
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump redirect and
// the EX/MEM register.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic               valid_d,
  input  logic [XLEN-1:0]    rd1_d,
  input  logic [XLEN-1:0]    rd2_d,
  input  logic [XLEN-1:0]    imm_ext_d,
  input  logic [XLEN-1:0]    pc_d,
  input  logic [XLEN-1:0]    pc_plus4_d,
  input  logic [RADDR_W-1:0] rs1_d,
  input  logic [RADDR_W-1:0] rs2_d,
  input  logic [RADDR_W-1:0] rd_d,
  input  logic [2:0]         alu_control_d,
  input  logic               alu_src_d,
  input  logic               reg_write_d,
  input  logic               mem_write_d,
  input  logic [1:0]         result_src_d,
  input  logic               branch_d,
  input  logic               jump_d,
  input  logic [1:0]         forward_a_e,
  input  logic [1:0]         forward_b_e,
  input  logic [XLEN-1:0]    result_w,
  output logic [RADDR_W-1:0] rs1_e,
  output logic [RADDR_W-1:0] rs2_e,
  output logic [RADDR_W-1:0] rd_e,
  output logic               result_src0_e,
  output logic               pc_src_e,
  output logic [XLEN-1:0]    pc_target_e,
  output logic [XLEN-1:0]    alu_result_m,
  output logic [XLEN-1:0]    write_data_m,
  output logic [RADDR_W-1:0] rd_m,
  output logic [XLEN-1:0]    pc_plus4_m,
  output logic               reg_write_m,
  output logic               mem_write_m,
  output logic               valid_m,
  output logic [1:0]         result_src_m
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [2:0]         alu_control;
    logic               alu_src;
    logic               reg_write;
    logic               mem_write;
    logic [1:0]         result_src;
    logic               branch;
    logic               jump;
  } id_ex_t;

  id_ex_t          de_d, de_e;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result_e;
  logic            zero_e;

  assign de_d = '{valid: valid_d, rd1: rd1_d, rd2: rd2_d, imm: imm_ext_d, pc: pc_d,
                  pc_plus4: pc_plus4_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                  alu_control: alu_control_d, alu_src: alu_src_d, reg_write: reg_write_d,
                  mem_write: mem_write_d, result_src: result_src_d, branch: branch_d,
                  jump: jump_d};

  // Flush wins over stall so a squashed instruction can never be held in EX.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst)           de_e <= '0;
    else if (flush_e)  de_e <= '0;
    else if (!stall_e) de_e <= de_d;
  end

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] reg_val,
                                               input logic [XLEN-1:0] wb_val,
                                               input logic [XLEN-1:0] mem_val);
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

  assign src_a = fwd_mux(forward_a_e, de_e.rd1, result_w, alu_result_m);
  assign fwd_b = fwd_mux(forward_b_e, de_e.rd2, result_w, alu_result_m);
  assign src_b = de_e.alu_src ? de_e.imm : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (de_e.alu_control),
    .result      (alu_result_e),
    .zero        (zero_e)
  );

  assign pc_target_e   = de_e.pc + de_e.imm;
  assign pc_src_e      = de_e.valid & (de_e.jump | (de_e.branch & zero_e));
  assign rs1_e         = de_e.rs1;
  assign rs2_e         = de_e.rs2;
  assign rd_e          = de_e.rd;
  assign result_src0_e = de_e.result_src[0];

  // EX/MEM never stalls; side effects are gated by valid so a bubble cannot write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      valid_m      <= 1'b0;
      result_src_m <= '0;
    end else begin
      alu_result_m <= alu_result_e;
      write_data_m <= fwd_b;
      rd_m         <= de_e.rd;
      pc_plus4_m   <= de_e.pc_plus4;
      reg_write_m  <= de_e.reg_write & de_e.valid;
      mem_write_m  <= de_e.mem_write & de_e.valid;
      valid_m      <= de_e.valid;
      result_src_m <= de_e.result_src;
    end
  end

endmodule
